// File: rtl/ysyx_22040759_if_stage.sv
// Instruction-fetch stage: owns the PC, fetches one instruction per req/gnt/rvalid
// transaction and hands {inst, pc} to decode through a valid/allowin handshake.
//
// state  | meaning
// S_REQ  | request asserted at pc, waiting for gnt
// S_WAIT | request accepted, waiting for rvalid (discard drops a wrong-path reply)
// S_HOLD | output occupied, next instruction parked in the skid buffer
module ysyx_22040759_if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ds_allowin,
  input  logic        pc_stall,
  input  logic [64:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [95:0] fs_to_ds_bus,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [63:0] pc, pc_n;
  logic [63:0] req_pc, req_pc_n;
  logic        out_valid, out_valid_n;
  logic [95:0] out_bus, out_bus_n;
  logic        skid_valid, skid_valid_n;
  logic [95:0] skid_bus, skid_bus_n;
  logic        discard, discard_n;

  logic        br_taken;
  logic [63:0] br_target;
  logic        drain;
  logic        out_free;
  logic [95:0] resp_bus;

  // Masking instead of slicing keeps every bit of br_bus in use.
  assign br_taken  = br_bus[64];
  assign br_target = br_bus[63:0] & ~64'h3;
  assign drain     = out_valid & ds_allowin & ~pc_stall;
  assign out_free  = ~out_valid | drain;
  assign resp_bus  = {imem_rdata, req_pc};

  assign imem_req       = (state == S_REQ) & ~rst;
  assign imem_addr      = pc;
  assign fs_to_ds_valid = out_valid;
  assign fs_to_ds_bus   = out_bus;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      out_valid  <= 1'b0;
      out_bus    <= '0;
      skid_valid <= 1'b0;
      skid_bus   <= '0;
      discard    <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      req_pc     <= req_pc_n;
      out_valid  <= out_valid_n;
      out_bus    <= out_bus_n;
      skid_valid <= skid_valid_n;
      skid_bus   <= skid_bus_n;
      discard    <= discard_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    req_pc_n     = req_pc;
    out_valid_n  = out_valid;
    out_bus_n    = out_bus;
    skid_valid_n = skid_valid;
    skid_bus_n   = skid_bus;
    discard_n    = discard;

    if (br_taken) begin
      // Redirect wins over stall and drain; anything already fetched is wrong-path.
      pc_n         = br_target;
      out_valid_n  = 1'b0;
      skid_valid_n = 1'b0;
      case (state)
        S_REQ: begin
          if (imem_gnt) begin
            req_pc_n  = pc;
            discard_n = 1'b1;
            state_n   = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            discard_n = 1'b0;
            state_n   = S_REQ;
          end else begin
            discard_n = 1'b1;
          end
        end
        S_HOLD: begin
          state_n = S_REQ;
        end
        default: begin
          state_n = S_REQ;
        end
      endcase
    end else begin
      if (drain) begin
        out_valid_n = 1'b0;
      end
      case (state)
        S_REQ: begin
          if (imem_gnt) begin
            req_pc_n = pc;
            state_n  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (discard) begin
              discard_n = 1'b0;
              state_n   = S_REQ;
            end else if (out_free) begin
              out_bus_n   = resp_bus;
              out_valid_n = 1'b1;
              pc_n        = req_pc + 64'd4;
              state_n     = S_REQ;
            end else begin
              skid_bus_n   = resp_bus;
              skid_valid_n = 1'b1;
              pc_n         = req_pc + 64'd4;
              state_n      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (drain && skid_valid) begin
            out_bus_n    = skid_bus;
            out_valid_n  = 1'b1;
            skid_valid_n = 1'b0;
            state_n      = S_REQ;
          end
        end
        default: begin
          state_n = S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040759_if_stage.sv
// Bench for the fetch stage: an imem responder plus a program-order model of the
// instruction stream decode should see (sequential PCs, restarted by redirects).
module tb_ysyx_22040759_if_stage;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int NSTEPS = 2500;

  logic        clk = 1'b0;
  logic        rst;
  logic        ds_allowin;
  logic        pc_stall;
  logic [64:0] br_bus;
  logic        fs_to_ds_valid;
  logic [95:0] fs_to_ds_bus;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  ysyx_22040759_if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .ds_allowin     (ds_allowin),
    .pc_stall       (pc_stall),
    .br_bus         (br_bus),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return ((a[31:0] ^ a[63:32]) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  logic [63:0] exp_pc, fetch_exp;
  logic        prev_rst, prev_br, prev_hold;
  logic [95:0] prev_bus;
  logic        pend;
  int          pend_due;
  logic [63:0] pend_addr;
  int          deliveries;
  logic        wrap_seen;
  logic        dir_br_done;
  int          rst_left, rst_done;

  logic        rst_now, allow, stall, g, br, spur, drain;
  logic [63:0] tgt;
  int          k;

  initial begin
    rst = 1'b1; ds_allowin = 1'b0; pc_stall = 1'b0; br_bus = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    exp_pc = RESET_PC; fetch_exp = RESET_PC;
    prev_rst = 1'b1; prev_br = 1'b0; prev_hold = 1'b0; prev_bus = '0;
    pend = 1'b0; pend_due = 0; pend_addr = '0;
    deliveries = 0; wrap_seen = 1'b0; dir_br_done = 1'b0;
    rst_left = 0; rst_done = 0;
    repeat (2) @(negedge clk);

    for (int s = 0; s < NSTEPS; s++) begin
      @(negedge clk);

      if (prev_rst) begin
        check_eq("rst_valid", 96'(fs_to_ds_valid), 96'd0);
        check_eq("rst_bus", fs_to_ds_bus, 96'd0);
        check_eq("rst_pc", 96'(imem_addr), 96'(RESET_PC));
      end else if (prev_br) begin
        check_eq("br_valid", 96'(fs_to_ds_valid), 96'd0);
      end else if (prev_hold) begin
        check_eq("hold_valid", 96'(fs_to_ds_valid), 96'd1);
        check_eq("hold_bus", fs_to_ds_bus, prev_bus);
      end
      if (s == 1) check_eq("lat_first", 96'(fs_to_ds_valid), 96'd0);
      if (s == 2) check_eq("lat_second", 96'(fs_to_ds_valid), 96'd1);

      // Stimulus: directed windows first, then randomized traffic.
      allow = ($urandom_range(0, 9) < 8);
      stall = ($urandom_range(0, 19) < 3);
      g     = ($urandom_range(0, 9) < 7);
      br    = ($urandom_range(0, 19) == 0);
      spur  = ($urandom_range(0, 9) == 0);
      k     = $urandom_range(1, 3);
      tgt   = ($urandom_range(0, 7) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                          : (64'h8000_0000 | 64'($urandom_range(0, 65535)));
      if (s < 26) begin
        allow = (s < 20); stall = 1'b0; g = 1'b1; br = 1'b0; spur = 1'b0; k = 1;
      end else if (s == 40) begin
        br = 1'b1; tgt = 64'hFFFF_FFFF_FFFF_FFFE;
      end else if (s > 40 && s <= 80) begin
        allow = 1'b1; stall = 1'b0; g = 1'b1; br = 1'b0; spur = 1'b0;
        k = (s <= 60) ? 1 : 3;
        if (s >= 65 && !dir_br_done && pend && s < pend_due) begin
          br = 1'b1; tgt = 64'h8000_0102; dir_br_done = 1'b1;
        end
      end

      if (rst_left == 0 && pend && s < pend_due &&
          ((s >= 900 && rst_done == 0) || (s >= 1700 && rst_done == 1))) begin
        rst_left = 5;
        rst_done++;
      end
      rst_now = 1'b0;
      if (rst_left > 0) begin
        rst_now = 1'b1;
        rst_left--;
      end

      if (pend && s == pend_due) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
      end else begin
        imem_rvalid = spur && !pend;
        imem_rdata  = $urandom;
      end
      rst        = rst_now;
      ds_allowin = allow;
      pc_stall   = stall;
      br_bus     = {br, tgt};
      imem_gnt   = g;
      #1;

      if (rst_now) check_eq("rst_noreq", 96'(imem_req), 96'd0);
      else if (imem_req) check_eq("addr_align", 96'(imem_addr[1:0]), 96'd0);

      drain = fs_to_ds_valid & ds_allowin & ~pc_stall;
      if (rst_now) begin
        exp_pc    = RESET_PC;
        fetch_exp = RESET_PC;
      end else if (br) begin
        exp_pc    = tgt & ~64'h3;
        fetch_exp = tgt & ~64'h3;
      end else begin
        if (drain) begin
          check_eq("ds_pc", 96'(fs_to_ds_bus[63:0]), 96'(exp_pc));
          check_eq("ds_inst", 96'(fs_to_ds_bus[95:64]), 96'(mem_word(exp_pc)));
          exp_pc = exp_pc + 64'd4;
          deliveries++;
        end
        if (imem_req && g) begin
          check_eq("fetch_addr", 96'(imem_addr), 96'(fetch_exp));
          if (s > 40 && imem_addr == 64'd0) wrap_seen = 1'b1;
          fetch_exp = fetch_exp + 64'd4;
        end
      end
      if (!rst_now && imem_req && g) begin
        pend      = 1'b1;
        pend_addr = imem_addr;
        pend_due  = s + k;
      end

      if (s == 19) check_eq("rate", 96'(deliveries), 96'd9);
      if (s == 25) begin
        check_eq("bp_noreq", 96'(imem_req), 96'd0);
        check_eq("bp_valid", 96'(fs_to_ds_valid), 96'd1);
      end
      if (s == 60) check_eq("wrap_seen", 96'(wrap_seen), 96'd1);

      prev_rst  = rst_now;
      prev_br   = br && !rst_now;
      prev_hold = fs_to_ds_valid && !drain && !br && !rst_now;
      prev_bus  = fs_to_ds_bus;
    end

    check_eq("dir_branch", 96'(dir_br_done), 96'd1);
    check_eq("reset_events", 96'(rst_done), 96'd2);
    check_eq("throughput", 96'(deliveries >= 150), 96'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
